// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC,
// issues word fetches to instruction memory over a req/ack handshake that
// tolerates variable latency, and presents {pc, pc+4, instruction, valid} to
// IF/ID. Stalls from the hazard unit are absorbed by a one-entry skid buffer.
// Redirects from ID discard stale and in-flight fetches. While no real
// instruction is available the NOP word is presented, so IF/ID latches a bubble.
//
// Ports:
//   clk_i          clock
//   rst_i          asynchronous, active-high reset
//   stall_i        IF/ID hold; the output slot is not consumed this cycle
//   redirect_i     branch taken / jump resolved in ID
//   redirect_pc_i  redirect target; bits [1:0] are ignored
//   imem_req_o     fetch request
//   imem_addr_o    fetch word address (bits [1:0] always 0)
//   imem_ack_i     response valid (may arrive in the same cycle as the request)
//   imem_rdata_i   instruction word, valid with ack
//   valid_o        output slot holds a real instruction
//   pc_o           PC of the slot instruction
//   pc_plus4_o     pc_o + 4, modulo 2^32
//   inst_o         slot instruction; NOP_WORD when valid_o = 0
//   bubble_cnt_o   (only with FETCH_STAT_EN) saturating count of bubbles
//                  delivered to IF/ID
//
// Build option: define FETCH_STAT_EN to add the bubble counter and its port.
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0020
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] inst_o
`ifdef FETCH_STAT_EN
    ,
    output logic [31:0] bubble_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_FULL  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t      state_r, state_s;

    logic [31:0] pc_r,         pc_s;
    logic [31:0] req_addr_r,   req_addr_s;

    // Output slot (drives IF/ID directly from registers)
    logic        valid_r,      valid_s;
    logic [31:0] slot_pc_r,    slot_pc_s;
    logic [31:0] slot_pc4_r,   slot_pc4_s;
    logic [31:0] slot_inst_r,  slot_inst_s;

    // One-entry skid buffer, filled only when a response lands on a held slot
    logic        skid_valid_r, skid_valid_s;
    logic [31:0] skid_pc_r,    skid_pc_s;
    logic [31:0] skid_inst_r,  skid_inst_s;

    logic        consume_s;
    logic        slot_free_s;
    logic        accept_s;

    assign consume_s   = valid_r & ~stall_i;
    assign slot_free_s = ~valid_r | consume_s;

    // Request interface: a retry after a miss must present the latched address
    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = pc_r;
        case (state_r)
            S_FETCH: begin
                imem_req_o  = 1'b1;
                imem_addr_o = pc_r;
            end
            S_WAIT, S_DROP: begin
                imem_req_o  = 1'b1;
                imem_addr_o = req_addr_r;
            end
            S_FULL: begin
                imem_req_o  = 1'b0;
                imem_addr_o = pc_r;
            end
            default: begin
                imem_req_o  = 1'b0;
                imem_addr_o = pc_r;
            end
        endcase
    end

    // Next-state and datapath update; redirect overrides stall and responses
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        req_addr_s   = req_addr_r;
        valid_s      = valid_r;
        slot_pc_s    = slot_pc_r;
        slot_pc4_s   = slot_pc4_r;
        slot_inst_s  = slot_inst_r;
        skid_valid_s = skid_valid_r;
        skid_pc_s    = skid_pc_r;
        skid_inst_s  = skid_inst_r;
        accept_s     = 1'b0;

        if (redirect_i) begin
            pc_s         = {redirect_pc_i[31:2], 2'b00};
            valid_s      = 1'b0;
            slot_inst_s  = NOP_WORD;
            skid_valid_s = 1'b0;
            case (state_r)
                S_FETCH: begin
                    // An unanswered request is still in flight; remember it
                    // so the drop state keeps presenting the same address.
                    if (!imem_ack_i) begin
                        state_s    = S_DROP;
                        req_addr_s = pc_r;
                    end else begin
                        state_s    = S_FETCH;
                    end
                end
                S_WAIT, S_DROP: begin
                    if (!imem_ack_i) begin
                        state_s = S_DROP;
                    end else begin
                        state_s = S_FETCH;
                    end
                end
                S_FULL: begin
                    state_s = S_FETCH;
                end
                default: begin
                    state_s = S_FETCH;
                end
            endcase
        end else begin
            if (consume_s) begin
                valid_s     = 1'b0;
                slot_inst_s = NOP_WORD;
            end else begin
                valid_s     = valid_r;
            end

            case (state_r)
                S_FETCH: begin
                    if (imem_ack_i) begin
                        accept_s   = 1'b1;
                    end else begin
                        req_addr_s = pc_r;
                        state_s    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ack_i) begin
                        accept_s = 1'b1;
                        state_s  = S_FETCH;
                    end else begin
                        state_s  = S_WAIT;
                    end
                end
                S_FULL: begin
                    if (consume_s) begin
                        valid_s      = 1'b1;
                        slot_pc_s    = skid_pc_r;
                        slot_pc4_s   = skid_pc_r + 32'd4;
                        slot_inst_s  = skid_inst_r;
                        skid_valid_s = 1'b0;
                        state_s      = S_FETCH;
                    end else begin
                        state_s      = S_FULL;
                    end
                end
                S_DROP: begin
                    if (imem_ack_i) begin
                        state_s = S_FETCH;
                    end else begin
                        state_s = S_DROP;
                    end
                end
                default: begin
                    state_s = S_FETCH;
                end
            endcase

            // The request address always equals pc_r here, so the arriving
            // word belongs to pc_r.
            if (accept_s) begin
                pc_s = pc_r + 32'd4;
                if (slot_free_s) begin
                    valid_s     = 1'b1;
                    slot_pc_s   = pc_r;
                    slot_pc4_s  = pc_r + 32'd4;
                    slot_inst_s = imem_rdata_i;
                end else begin
                    skid_valid_s = 1'b1;
                    skid_pc_s    = pc_r;
                    skid_inst_s  = imem_rdata_i;
                    state_s      = S_FULL;
                end
            end else begin
                pc_s = pc_s;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_s;
        end
    end

    // PC, request address, output slot and skid registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_r         <= RESET_PC;
            req_addr_r   <= RESET_PC;
            valid_r      <= 1'b0;
            slot_pc_r    <= 32'h0000_0000;
            slot_pc4_r   <= 32'h0000_0004;
            slot_inst_r  <= NOP_WORD;
            skid_valid_r <= 1'b0;
            skid_pc_r    <= 32'h0000_0000;
            skid_inst_r  <= NOP_WORD;
        end else begin
            pc_r         <= pc_s;
            req_addr_r   <= req_addr_s;
            valid_r      <= valid_s;
            slot_pc_r    <= slot_pc_s;
            slot_pc4_r   <= slot_pc4_s;
            slot_inst_r  <= slot_inst_s;
            skid_valid_r <= skid_valid_s;
            skid_pc_r    <= skid_pc_s;
            skid_inst_r  <= skid_inst_s;
        end
    end

    assign valid_o    = valid_r;
    assign pc_o       = slot_pc_r;
    assign pc_plus4_o = slot_pc4_r;
    assign inst_o     = slot_inst_r;

`ifdef FETCH_STAT_EN
    logic [31:0] bubble_cnt_r;

    // Saturating count of bubbles actually handed to IF/ID
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bubble_cnt_r <= 32'h0000_0000;
        end else if (!valid_r && !stall_i && (bubble_cnt_r != 32'hFFFF_FFFF)) begin
            bubble_cnt_r <= bubble_cnt_r + 32'd1;
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    assign bubble_cnt_o = bubble_cnt_r;
`endif

endmodule
